// File: rtl/wash_seq_if.sv
// Handshake/bus bundle for the wash sequencer: user controls in, status out.
// The master drives buttons, mode and balance; the slave is the sequencer.
interface wash_seq_if #(
  parameter int N_MODES = 3,
  parameter int W_BAL   = 12,
  parameter int W_T     = 10
) ();
  localparam int MW = $clog2(N_MODES);

  logic                    start;
  logic                    pause;
  logic [MW-1:0]           mode;
  logic signed [W_BAL-1:0] bal_in;
  logic signed [W_BAL-1:0] bal_out;
  logic [2:0]              phase;
  logic [W_T-1:0]          remain_s;
  logic                    busy;
  logic                    done;
  logic [7:0]              st_light;

  modport master (
    output start, pause, mode, bal_in,
    input  bal_out, phase, remain_s, busy, done, st_light
  );

  modport slave (
    input  start, pause, mode, bal_in,
    output bal_out, phase, remain_s, busy, done, st_light
  );
endinterface

// File: rtl/wash_seq.sv
// Coin-operated washing machine sequencer: charge, then WASH -> RINSE -> SPIN -> DONE,
// with a pausable per-second countdown and an abort after a long pause.
module wash_seq #(
  parameter int N_MODES     = 3,
  parameter int TICK_DIV    = 100000000,
  parameter int W_BAL       = 12,
  parameter int W_T         = 10,
  parameter int WASH_S      = 20,
  parameter int RINSE_S     = 10,
  parameter int SPIN_S      = 5,
  parameter int PRICE_UNIT  = 10,
  parameter int PAUSE_MAX_S = 60
) (
  input logic       clk,
  input logic       rst,
  wash_seq_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(PAUSE_MAX_S + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_MAX_S - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } phase_t;

  phase_t                  state;
  phase_t                  ret_phase;
  logic [PW-1:0]           presc;
  logic [PW-1:0]           pause_div;
  logic [CW-1:0]           pause_s;
  logic [W_T-1:0]          remain;
  logic                    aborted;
  logic                    done_q;
  logic signed [W_BAL-1:0] bal_q;

  // Price check is done one bit wider so a negative balance never wraps into "affordable".
  logic signed [W_BAL:0] price;
  logic signed [W_BAL:0] bal_ext;
  logic                  mode_ok;
  logic                  afford;
  logic [W_T-1:0]        wash_len;
  logic                  tick;
  logic                  pause_tick;

  assign price      = (W_BAL+1)'(PRICE_UNIT * (32'(bus.mode) + 1));
  assign bal_ext    = {bus.bal_in[W_BAL-1], bus.bal_in};
  assign afford     = bal_ext >= price;
  assign mode_ok    = 32'(bus.mode) < N_MODES;
  assign wash_len   = W_T'(WASH_S * (32'(bus.mode) + 1));
  assign tick       = presc == PRESC_LAST;
  assign pause_tick = pause_div == PRESC_LAST;

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ret_phase <= IDLE;
      presc     <= '0;
      pause_div <= '0;
      pause_s   <= '0;
      remain    <= '0;
      aborted   <= 1'b0;
      done_q    <= 1'b0;
      bal_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (mode_ok && afford) begin
              state  <= WASH;
              bal_q  <= W_BAL'(bal_ext - price);
              remain <= wash_len;
              presc  <= '0;
            end else begin
              state <= ERR;
            end
          end else begin
            bal_q <= bus.bal_in;
          end
        end
        WASH, RINSE, SPIN: begin
          // A pause on the tick cycle leaves presc at its last value, so the tick fires on resume.
          if (bus.pause) begin
            ret_phase <= state;
            state     <= PAUSE;
            pause_div <= '0;
            pause_s   <= '0;
          end else if (tick) begin
            presc <= '0;
            if (remain == W_T'(1)) begin
              case (state)
                WASH: begin
                  state  <= RINSE;
                  remain <= W_T'(RINSE_S);
                end
                RINSE: begin
                  state  <= SPIN;
                  remain <= W_T'(SPIN_S);
                end
                default: begin
                  state  <= DONE;
                  remain <= '0;
                  done_q <= 1'b1;
                end
              endcase
            end else begin
              remain <= remain - 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (bus.pause) begin
            state <= ret_phase;
          end else if (pause_tick) begin
            pause_div <= '0;
            if (pause_s == PAUSE_LAST) begin
              state   <= DONE;
              remain  <= '0;
              aborted <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              pause_s <= pause_s + 1'b1;
            end
          end else begin
            pause_div <= pause_div + 1'b1;
          end
        end
        DONE, ERR: begin
          if (bus.start) begin
            state   <= IDLE;
            aborted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bal_out  = bal_q;
  assign bus.phase    = state;
  assign bus.remain_s = remain;
  assign bus.busy     = state inside {WASH, RINSE, SPIN, PAUSE};
  assign bus.done     = done_q;
  assign bus.st_light = {aborted, 7'b1 << state};
endmodule

// File: tb/tb_wash_seq.sv
// Scoreboard bench for wash_seq at TICK_DIV=4: expected snapshots are queued by cycle
// number as stimulus is planned and compared on the falling edge of that cycle.
module tb_wash_seq;
  localparam int TD = 4;
  localparam int P_IDLE = 0, P_WASH = 1, P_RINSE = 2, P_SPIN = 3;
  localparam int P_PAUSE = 4, P_DONE = 5, P_ERR = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    int cyc;
    int ph;
    int rem;
    int bal;
    int lt;
    int dn;
  } exp_t;

  exp_t sb[$];

  wash_seq_if #(.N_MODES(3), .W_BAL(12), .W_T(10)) bus ();

  wash_seq #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, want);
  endtask

  // Queue stays sorted by cycle so expectations can be planned in any order.
  function automatic void exp_at(input int c, input int ph, input int rem, input int bal,
                                 input int lt, input int dn);
    exp_t x;
    int   i;
    x = '{c, ph, rem, bal, lt, dn};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, x);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        check("sb_missed", e.cyc, cyc);
      end else begin
        check("phase", int'(bus.phase), e.ph);
        check("remain_s", int'(bus.remain_s), e.rem);
        check("bal_out", int'(bus.bal_out), e.bal);
        check("st_light", int'(bus.st_light), e.lt);
        check("done", int'(bus.done), e.dn);
        check("busy", int'(bus.busy), (e.ph >= P_WASH && e.ph <= P_PAUSE) ? 1 : 0);
      end
    end
  end

  task automatic pulse(input logic s, input logic p);
    bus.start = s;
    bus.pause = p;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Presents balance/mode one cycle early so bal_out already reflects it, then starts.
  task automatic try_start(input int bal, input int md, input int ph, input int rem,
                           input int bal_exp, input int lt, output int entry);
    bus.bal_in = 12'(bal);
    bus.mode   = 2'(md);
    @(negedge clk);
    entry = cyc + 1;
    exp_at(entry, ph, rem, bal_exp, lt, 0);
    pulse(1'b1, 1'b0);
  endtask

  task automatic go_idle(input int bal_exp);
    exp_at(cyc + 1, P_IDLE, 0, bal_exp, 8'h01, 0);
    pulse(1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e, p, r, x, q, r2, s, s2;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.mode   = 2'd0;
    bus.bal_in = 12'sd100;
    rst        = 1'b0;

    // Reset holds everything cleared even with a live balance on bal_in.
    @(negedge clk);
    exp_at(2, P_IDLE, 0, 0, 8'h01, 0);
    exp_at(3, P_IDLE, 0, 0, 8'h01, 0);
    wait_until(3);
    rst = 1'b1;
    exp_at(4, P_IDLE, 0, 100, 8'h01, 0);
    @(negedge clk);
    bus.bal_in = 12'sd60;
    exp_at(5, P_IDLE, 0, 60, 8'h01, 0);
    @(negedge clk);

    // Full program mode 1: 40 s wash, 10 s rinse, 5 s spin.
    try_start(100, 1, P_WASH, 40, 80, 8'h02, e);
    exp_at(e + 3,   P_WASH, 40, 80, 8'h02, 0);
    exp_at(e + 4,   P_WASH, 39, 80, 8'h02, 0);
    exp_at(e + 50,  P_WASH, 28, 80, 8'h02, 0);
    exp_at(e + 159, P_WASH, 1,  80, 8'h02, 0);
    exp_at(e + 160, P_RINSE, 10, 80, 8'h04, 0);
    exp_at(e + 199, P_RINSE, 1,  80, 8'h04, 0);
    exp_at(e + 200, P_SPIN, 5,  80, 8'h08, 0);
    exp_at(e + 219, P_SPIN, 1,  80, 8'h08, 0);
    exp_at(e + 220, P_DONE, 0,  80, 8'h20, 1);
    exp_at(e + 221, P_DONE, 0,  80, 8'h20, 0);
    exp_at(e + 225, P_DONE, 0,  80, 8'h20, 0);
    wait_until(e + 49);
    pulse(1'b1, 1'b0);              // start ignored while washing
    wait_until(e + 224);
    pulse(1'b0, 1'b1);              // pause ignored in DONE
    wait_until(e + 227);
    go_idle(80);
    exp_at(cyc + 1, P_IDLE, 0, 100, 8'h01, 0);
    @(negedge clk);
    @(negedge clk);

    // Insufficient balance, pause ignored in ERR, start returns to IDLE.
    try_start(5, 0, P_ERR, 0, 5, 8'h40, e);
    exp_at(cyc + 1, P_ERR, 0, 5, 8'h40, 0);
    pulse(1'b0, 1'b1);
    go_idle(5);

    // Out-of-range mode, negative balance, and one unit short of the price.
    try_start(100, 3, P_ERR, 0, 100, 8'h40, e);
    go_idle(100);
    try_start(-5, 0, P_ERR, 0, -5, 8'h40, e);
    go_idle(-5);
    try_start(29, 2, P_ERR, 0, 29, 8'h40, e);
    go_idle(29);

    // Start and pause together in IDLE: only start acts.
    bus.bal_in = 12'sd100;
    bus.mode   = 2'd0;
    @(negedge clk);
    e = cyc + 1;
    exp_at(e, P_WASH, 20, 90, 8'h02, 0);
    pulse(1'b1, 1'b1);

    // Pause 10 cycles into WASH, hold 20, resume: the 9 run edges plus 71 more reach RINSE.
    p = e + 10;
    r = p + 20;
    x = e + 101;
    exp_at(p - 1, P_WASH, 18, 90, 8'h02, 0);
    exp_at(p,     P_PAUSE, 18, 90, 8'h10, 0);
    exp_at(p + 5, P_PAUSE, 18, 90, 8'h10, 0);
    exp_at(p + 19, P_PAUSE, 18, 90, 8'h10, 0);
    exp_at(r,     P_WASH, 18, 90, 8'h02, 0);
    exp_at(r + 2, P_WASH, 18, 90, 8'h02, 0);
    exp_at(r + 3, P_WASH, 17, 90, 8'h02, 0);
    exp_at(x - 1, P_WASH, 1,  90, 8'h02, 0);
    exp_at(x,     P_RINSE, 10, 90, 8'h04, 0);
    wait_until(p - 1);
    pulse(1'b0, 1'b1);
    wait_until(p + 4);
    pulse(1'b1, 1'b0);              // start ignored while paused
    wait_until(r - 1);
    pulse(1'b0, 1'b1);

    // Pause lands on a tick edge; the deferred tick fires on the first edge after resume.
    q  = x + 4;
    r2 = q + 4;
    s  = r2 + 37;
    exp_at(x + 3,   P_RINSE, 10, 90, 8'h04, 0);
    exp_at(q,       P_PAUSE, 10, 90, 8'h10, 0);
    exp_at(r2,      P_RINSE, 10, 90, 8'h04, 0);
    exp_at(r2 + 1,  P_RINSE, 9,  90, 8'h04, 0);
    exp_at(r2 + 36, P_RINSE, 1,  90, 8'h04, 0);
    exp_at(s,       P_SPIN,  5,  90, 8'h08, 0);
    wait_until(q - 1);
    pulse(1'b0, 1'b1);
    wait_until(r2 - 1);
    pulse(1'b0, 1'b1);

    // A 60 s pause aborts to DONE with no refund.
    s2 = s + 2;
    exp_at(s2,       P_PAUSE, 5, 90, 8'h10, 0);
    exp_at(s2 + 239, P_PAUSE, 5, 90, 8'h10, 0);
    exp_at(s2 + 240, P_DONE,  0, 90, 8'hA0, 1);
    exp_at(s2 + 241, P_DONE,  0, 90, 8'hA0, 0);
    wait_until(s2 - 1);
    pulse(1'b0, 1'b1);
    wait_until(s2 + 242);
    go_idle(90);
    exp_at(cyc + 1, P_IDLE, 0, 100, 8'h01, 0);
    @(negedge clk);

    // Exact-price boundary on mode 2, then reset during SPIN abandons the program.
    try_start(30, 2, P_WASH, 60, 0, 8'h02, e);
    exp_at(e + 280, P_SPIN, 5, 0, 8'h08, 0);
    exp_at(e + 282, P_IDLE, 0, 0, 8'h01, 0);
    exp_at(e + 283, P_IDLE, 0, 30, 8'h01, 0);
    wait_until(e + 281);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    try_start(0, 0, P_ERR, 0, 0, 8'h40, e);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
